// File: rtl/add_64.sv
// 64-bit ripple-carry adder for the y86-64 ALU ADD path.
// A chain of single-bit full adders (carry-in fixed at 0) produces the sum and
// the per-bit carry-out vector; both, plus the signed-overflow flag, are
// registered with one clock of latency. There is no handshake: a new operand
// pair is accepted on every rising edge and its result is visible right after
// that edge.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  // Single-bit sum and carry-out.
  always_comb begin
    s     = a ^ b ^ c_in;
    c_out = (a & b) | (c_in & (a ^ b));
  end

endmodule

module add_64 #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry,
  output logic         overflow
);

  // chain[i] is the carry into bit i; chain[i+1] is the carry out of bit i.
  logic [N:0]   chain;
  logic [N-1:0] s_comb;
  logic [N-1:0] co_comb;
  logic         ovf_comb;

  assign chain[0] = 1'b0;

  // Ripple chain of N full adders; each stage feeds the next stage's carry-in.
  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (chain[i]),
      .s     (s_comb[i]),
      .c_out (chain[i+1])
    );
  end

  assign co_comb = chain[N:1];

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf_comb = co_comb[N-1] ^ co_comb[N-2];
  end

  // Output register stage; a low rst_n on an edge discards the in-flight result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum      <= '0;
      carry    <= '0;
      overflow <= 1'b0;
    end else begin
      sum      <= s_comb;
      carry    <= co_comb;
      overflow <= ovf_comb;
    end
  end

endmodule

// File: tb/tb_add_64.sv
// Self-checking bench for add_64: directed table, a multi-cycle reset
// sequence, and randomized operands checked against an arithmetic model.

module tb_add_64;

  localparam int W = 64;
  localparam int EW = 2 * W + 1;  // {sum, carry, overflow}

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic [W-1:0] carry;
  logic         overflow;

  int n_vec  = 0;
  int n_miss = 0;

  logic [EW-1:0] exp_q[$];

  add_64 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain wide addition. The carry into bit i equals
  // bit i of (a + b) ^ a ^ b, so carry-out of bit i is carry-in of bit i+1;
  // the carry-out of the top bit is bit 64 of the 65-bit sum.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W:0]   s65;
    logic [W-1:0] cin;
    logic [W-1:0] cv;
    logic         ov;
    s65 = {1'b0, ma} + {1'b0, mb};
    cin = s65[W-1:0] ^ ma ^ mb;
    cv  = {s65[W], cin[W-1:1]};
    ov  = (ma[W-1] == mb[W-1]) && (s65[W-1] != ma[W-1]);
    return {s65[W-1:0], cv, ov};
  endfunction

  // Driver + scoreboard: drive one operand pair on the falling edge, queue the
  // expected result, then compare just after the next rising edge.
  task automatic apply(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic trst,
                       input logic [EW-1:0] expv, input logic [W-1:0] cmask, input string name);
    logic [EW-1:0] e;
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    rst_n = trst;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if ((sum !== e[EW-1:W+1]) || ((carry & cmask) !== (e[W:1] & cmask)) || (overflow !== e[0])) begin
      n_miss++;
      $display("FAIL %s: a=%h b=%h got sum=%h carry=%h ovf=%b, expected sum=%h carry=%h (mask %h) ovf=%b",
               name, ta, tb_v, sum, carry, overflow, e[EW-1:W+1], e[W:1], cmask, e[0]);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         rst_n;
    logic [W-1:0] sum;
    logic [W-1:0] carry;
    logic [W-1:0] cmask;
    logic         ovf;
    string        name;
  } vec_t;

  localparam logic [W-1:0] ALL  = {W{1'b1}};
  localparam logic [W-1:0] MAXP = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MINN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] TOP  = {1'b1, {(W-1){1'b0}}};

  vec_t tbl[7];

  initial begin
    logic [W-1:0] ra, rb, x1, x2, x3, x4;
    logic         rr;

    a     = 64'd5;
    b     = 64'd7;
    rst_n = 1'b0;

    // Directed table: {a, b, rst_n, sum, carry, carry mask, ovf, name}
    tbl[0] = '{64'd5, 64'd7, 1'b0, 64'd0, 64'd0, ALL, 1'b0, "reset_edge1"};
    tbl[1] = '{64'd5, 64'd7, 1'b0, 64'd0, 64'd0, ALL, 1'b0, "reset_edge2"};
    tbl[2] = '{64'd999999999, 64'd12345, 1'b1, 64'd1000012344, 64'd0, TOP, 1'b0, "first_after_reset"};
    tbl[3] = '{64'd10, 64'd3, 1'b1, 64'd13, 64'h2, ALL, 1'b0, "ten_plus_three"};
    tbl[4] = '{ALL, 64'd1, 1'b1, 64'd0, ALL, ALL, 1'b0, "minus1_plus1"};
    tbl[5] = '{MAXP, 64'd1, 1'b1, MINN, MAXP, ALL, 1'b1, "maxpos_plus1"};
    tbl[6] = '{MINN, MINN, 1'b1, 64'd0, TOP, ALL, 1'b1, "minneg_plus_minneg"};

    for (int i = 0; i < 7; i++) begin
      apply(tbl[i].a, tbl[i].b, tbl[i].rst_n,
            {tbl[i].sum, tbl[i].carry, tbl[i].ovf}, tbl[i].cmask, tbl[i].name);
    end

    // Back-to-back stream with reset pulsed on the third cycle.
    x1 = 64'h0123_4567_89AB_CDEF;
    x2 = 64'hFEDC_BA98_7654_3210;
    x3 = 64'h8000_0000_0000_0001;
    x4 = 64'h7FFF_FFFF_0000_FFFF;
    apply(x1, x2, 1'b1, model(x1, x2), ALL, "stream_c1");
    apply(x3, x4, 1'b1, model(x3, x4), ALL, "stream_c2");
    apply(x4, x4, 1'b0, '0, ALL, "stream_reset_c3");
    apply(x4, x4, 1'b1, model(x4, x4), ALL, "stream_resume_c4");
    apply(x3, x3, 1'b1, model(x3, x3), ALL, "stream_c5");
    apply(x1, x1, 1'b1, model(x1, x1), ALL, "stream_c6");

    // Randomized operands, biased toward sign/carry boundary patterns,
    // with an occasional reset cycle mixed in.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       ra = ALL;
        1:       ra = MAXP;
        2:       ra = MINN;
        default: ra = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 64'd1;
        1:       rb = ALL;
        2:       rb = ~ra;
        default: rb = {$urandom, $urandom};
      endcase
      rr = ($urandom_range(0, 31) != 0);
      apply(ra, rb, rr, rr ? model(ra, rb) : '0, ALL, rr ? "random" : "random_reset");
    end

    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
